// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares the memory-mapped UART transmitter among N
// byte-stream requesters, acting as a second bus master beside the CPU.
module uart_tx_sched #(
  parameter int          N        = 4,
  parameter logic [31:0] BASE     = 32'hFFFF0020,
  parameter int          POLL_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  output logic             busy
);

  // state  | meaning
  // INIT   | enable the transmitter (CTRL write), once after reset
  // IDLE   | wait for a requester, latch winner and its byte
  // POLL   | read STAT until the transmitter is free
  // GAP    | back off POLL_GAP cycles between polls
  // WRITE  | write the latched byte to TXDT
  // SETTLE | ack pulse to the winner; dead cycle so STAT busy can rise
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POLL, S_GAP, S_WRITE, S_SETTLE
  } state_t;

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [31:0] ADDR_TXDT = BASE + 32'h4;
  localparam logic [31:0] ADDR_CTRL = BASE + 32'h8;
  localparam logic [31:0] ADDR_STAT = BASE + 32'hC;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [7:0]      tx_byte;
  logic [GW-1:0]   gap_cnt;
  logic            bus_req_r;
  logic            we_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
  logic [N-1:0]    req_ready_r;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   scan_idx;
  logic [7:0]      win_byte;

  // Scan downward so the candidate closest after rr_ptr is assigned last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % N);
      if (req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  // Bus registers hold the access for the state being entered, so the
  // address is already stable when bus_rdata is sampled in POLL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_INIT;
      rr_ptr      <= PW'(N - 1);
      win         <= '0;
      tx_byte     <= '0;
      gap_cnt     <= '0;
      bus_req_r   <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      req_ready_r <= '0;
    end else begin
      req_ready_r <= '0;
      case (state)
        S_INIT: begin
          if (!bus_req_r) begin
            bus_req_r <= 1'b1;
            we_r      <= 1'b1;
            addr_r    <= ADDR_CTRL;
            wdata_r   <= 32'h2;
          end else if (bus_gnt) begin
            bus_req_r <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (win_found) begin
            win       <= win_idx;
            tx_byte   <= win_byte;
            bus_req_r <= 1'b1;
            we_r      <= 1'b0;
            addr_r    <= ADDR_STAT;
            wdata_r   <= '0;
            state     <= S_POLL;
          end
        end
        S_POLL: begin
          if (bus_gnt) begin
            if (!bus_rdata[1]) begin
              we_r    <= 1'b1;
              addr_r  <= ADDR_TXDT;
              wdata_r <= {24'b0, tx_byte};
              state   <= S_WRITE;
            end else begin
              bus_req_r <= 1'b0;
              addr_r    <= '0;
              gap_cnt   <= GW'(POLL_GAP - 1);
              state     <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            bus_req_r <= 1'b1;
            we_r      <= 1'b0;
            addr_r    <= ADDR_STAT;
            state     <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          if (bus_gnt) begin
            bus_req_r   <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            req_ready_r <= N'(1) << win;
            rr_ptr      <= win;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: state <= S_IDLE;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Nothing reaches the shared bus without the grant.
  assign bus_req   = bus_req_r;
  assign bus_we    = we_r & bus_gnt;
  assign bus_addr  = bus_gnt ? addr_r : '0;
  assign bus_wdata = bus_gnt ? wdata_r : '0;
  assign req_ready = req_ready_r;
  assign busy      = rst & (state != S_IDLE);

  logic unused_rdata;
  assign unused_rdata = ^{bus_rdata[31:2], bus_rdata[0]};

endmodule
